// File: rtl/vga_sync_rx_if.sv
// Sync bundle between a VGA timing source and the sync receiver: hsync/vsync in,
// recovered raster and lock status out.
interface vga_sync_rx_if;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic        locked;
  logic        frame_start;
  logic [11:0] line_len;
  logic [11:0] frame_lines;
  logic        err;
  logic [7:0]  err_cnt;

  modport master (
    output hsync,
    output vsync,
    input  de,
    input  x_pos,
    input  y_pos,
    input  locked,
    input  frame_start,
    input  line_len,
    input  frame_lines,
    input  err,
    input  err_cnt
  );

  modport slave (
    input  hsync,
    input  vsync,
    output de,
    output x_pos,
    output y_pos,
    output locked,
    output frame_start,
    output line_len,
    output frame_lines,
    output err,
    output err_cnt
  );
endinterface

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: measures line/frame periods against the expected mode, tracks lock and
// recovers the active-area data enable with pixel/line coordinates.
module vga_sync_rx #(
  parameter int unsigned H_TOTAL     = 1040,
  parameter int unsigned V_TOTAL     = 666,
  parameter int unsigned H_ACT_START = 187,
  parameter int unsigned H_ACT       = 800,
  parameter int unsigned V_ACT_START = 31,
  parameter int unsigned V_ACT       = 600
) (
  input logic          clk,
  input logic          rst,
  vga_sync_rx_if.slave bus_io
);

  localparam logic [11:0] HTotal    = 12'(H_TOTAL);
  localparam logic [11:0] VTotal    = 12'(V_TOTAL);
  localparam logic [11:0] HActStart = 12'(H_ACT_START);
  localparam logic [11:0] HActEnd   = 12'(H_ACT_START + H_ACT);
  localparam logic [11:0] VActStart = 12'(V_ACT_START);
  localparam logic [11:0] VActEnd   = 12'(V_ACT_START + V_ACT);
  localparam logic [11:0] CntMax    = 12'hfff;

  typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

  state_e      state_q, state_d;
  logic        bad_q, bad_d;
  logic        hs_q, vs_q;
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic        vs_pend_q, vs_pend_d;
  logic [11:0] line_len_q, line_len_d;
  logic [11:0] frame_lines_q, frame_lines_d;
  logic        fs_q;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        de_q, de_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;

  logic        hs_fall, vs_fall, fs_ev;
  logic        line_err, frame_err, any_err;
  logic [11:0] h_inc, v_inc;
  logic        h_in_win, v_in_win;

  assign hs_fall = hs_q & ~bus_io.hsync;
  assign vs_fall = vs_q & ~bus_io.vsync;
  // A vsync edge landing on the same clock as the hsync edge starts the frame immediately.
  assign fs_ev   = hs_fall & (vs_pend_q | vs_fall);

  assign h_inc = h_cnt_q + 12'd1;
  assign v_inc = v_cnt_q + 12'd1;

  // Counters only pass the expected total once per line/frame, so the timeout fires once.
  assign line_err  = hs_fall ? (h_inc != HTotal) : (h_cnt_q == HTotal);
  assign frame_err = fs_ev ? (v_inc != VTotal) : (v_cnt_q == VTotal);
  assign any_err   = line_err | frame_err;

  assign h_in_win = (h_cnt_q >= HActStart) && (h_cnt_q < HActEnd);
  assign v_in_win = (v_cnt_q >= VActStart) && (v_cnt_q < VActEnd);

  // Line/frame measurement.
  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    vs_pend_d     = vs_pend_q | vs_fall;

    if (hs_fall) begin
      h_cnt_d    = 12'd0;
      line_len_d = h_inc;
    end else if (h_cnt_q != CntMax) begin
      h_cnt_d = h_inc;
    end

    if (fs_ev) begin
      frame_lines_d = v_inc;
      v_cnt_d       = 12'd0;
      vs_pend_d     = 1'b0;
    end else if (hs_fall && (v_cnt_q != CntMax)) begin
      v_cnt_d = v_inc;
    end
  end

  // Lock FSM next state.
  always_comb begin
    state_d = state_q;
    bad_d   = bad_q;
    unique case (state_q)
      StSearch: begin
        if (fs_ev) begin
          state_d = StTrack;
          bad_d   = 1'b0;
        end
      end
      StTrack: begin
        if (fs_ev) begin
          bad_d = 1'b0;
          if (!bad_q && !any_err) begin
            state_d = StLocked;
          end
        end else if (any_err) begin
          bad_d = 1'b1;
        end
      end
      StLocked: begin
        if (any_err) begin
          state_d = StSearch;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  // Lock FSM outputs; de follows the next state so it drops together with locked.
  always_comb begin
    err_d     = (state_q == StLocked) && any_err;
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hff)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
    de_d = (state_d == StLocked) && h_in_win && v_in_win;
    x_d  = de_d ? (h_cnt_q - HActStart) : 12'd0;
    y_d  = de_d ? (v_cnt_q - VActStart) : 12'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StSearch;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bad_q   <= bad_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      h_cnt_q       <= 12'd0;
      v_cnt_q       <= 12'd0;
      vs_pend_q     <= 1'b0;
      line_len_q    <= 12'd0;
      frame_lines_q <= 12'd0;
      fs_q          <= 1'b0;
      err_q         <= 1'b0;
      err_cnt_q     <= 8'd0;
      de_q          <= 1'b0;
      x_q           <= 12'd0;
      y_q           <= 12'd0;
    end else begin
      hs_q          <= bus_io.hsync;
      vs_q          <= bus_io.vsync;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      vs_pend_q     <= vs_pend_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      fs_q          <= fs_ev;
      err_q         <= err_d;
      err_cnt_q     <= err_cnt_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
    end
  end

  assign bus_io.de          = de_q;
  assign bus_io.x_pos       = x_q;
  assign bus_io.y_pos       = y_q;
  assign bus_io.locked      = (state_q == StLocked);
  assign bus_io.frame_start = fs_q;
  assign bus_io.line_len    = line_len_q;
  assign bus_io.frame_lines = frame_lines_q;
  assign bus_io.err         = err_q;
  assign bus_io.err_cnt     = err_cnt_q;

endmodule
